note_recorder: RTL

//  Writer side of the 64 x 32 song RAM that the tempo-driven player reads by address.

---
 rtl/note_recorder_if.sv | 32 +++
 rtl/note_recorder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/note_recorder_if.sv
// Song RAM writer bus: tempo/control inputs toward the recorder, RAM write port
// and take status back out.
`timescale 1ns/1ps
interface note_recorder_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int NOTE_W = 7
) ();
   logic                tick;
   logic                start;
   logic                stop;
   logic [NOTE_W-1:0]   note_in;
   logic                wren;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                busy;
   logic                done;
   logic                full;
   logic [ADDR_W:0]     length;

   // Controller / testbench side
   modport master (
      output tick, start, stop, note_in,
      input  wren, wr_addr, wr_data, busy, done, full, length
   );

   // Recorder side
   modport slave (
      input  tick, start, stop, note_in,
      output wren, wr_addr, wr_data, busy, done, full, length
   );
endinterface

// File: rtl/note_recorder.sv
// Note recorder: samples a note code on each tempo tick, run-length encodes it
// into one {note, duration} word per run and writes the take into the song RAM,
// closing it with an all-zero end marker unless the RAM filled up.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | after reset, waiting for start
// WAIT_TICK | take armed, waiting for the first tick to open a run
// RECORD    | a run is open; each tick extends it or commits it
// FLUSH     | stop seen: commit the open run
// MARK      | write the zero end-marker after the last run
// DONE      | take finished; status held until the next start
`timescale 1ns/1ps
module note_recorder #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int NOTE_W = 7,
   parameter int DUR_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   note_recorder_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_TICK = 3'd1,
      S_RECORD    = 3'd2,
      S_FLUSH     = 3'd3,
      S_MARK      = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
   localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);

   state_t              r_state;
   logic [NOTE_W-1:0]   r_cur_note;
   logic [DUR_W-1:0]    r_dur;
   logic [ADDR_W-1:0]   r_next_addr;

   logic                r_wren;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_busy;
   logic                r_done;
   logic                r_full;
   logic [ADDR_W:0]     r_length;

   logic [DATA_W-1:0]   w_run_word;
   logic                w_same_note;
   logic                w_dur_sat;
   logic                w_last_slot;

   // Pack the open run into a RAM word; bits above the note field stay zero.
   always_comb begin
      w_run_word                  = '0;
      w_run_word[DUR_W-1:0]       = r_dur;
      w_run_word[DUR_W +: NOTE_W] = r_cur_note;
   end

   assign w_same_note = (bus.note_in == r_cur_note);
   assign w_dur_sat   = (r_dur == DUR_MAX);
   assign w_last_slot = (r_next_addr == LAST_ADDR);

   // Take sequencer; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_cur_note  <= '0;
         r_dur       <= '0;
         r_next_addr <= '0;
         r_wren      <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_full      <= 1'b0;
         r_length    <= '0;
      end else begin
         r_wren <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_state     <= S_WAIT_TICK;
                  r_next_addr <= '0;
                  r_length    <= '0;
                  r_full      <= 1'b0;
                  r_done      <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end

            S_WAIT_TICK: begin
               if (bus.stop) begin
                  // Nothing was recorded, so there is no run and no marker.
                  r_state  <= S_DONE;
                  r_length <= '0;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else if (bus.tick) begin
                  r_state    <= S_RECORD;
                  r_cur_note <= bus.note_in;
                  r_dur      <= DUR_ONE;
               end
            end

            S_RECORD: begin
               if (bus.stop) begin
                  // A tick in the same cycle is dropped so the open run is
                  // flushed exactly as it stood.
                  r_state <= S_FLUSH;
               end else if (bus.tick) begin
                  if (w_same_note && !w_dur_sat) begin
                     r_dur <= r_dur + DUR_ONE;
                  end else begin
                     r_wren     <= 1'b1;
                     r_wr_addr  <= r_next_addr;
                     r_wr_data  <= w_run_word;
                     r_length   <= r_length + LEN_ONE;
                     r_cur_note <= bus.note_in;
                     r_dur      <= DUR_ONE;
                     if (w_last_slot) begin
                        // RAM is full: the run just opened has nowhere to go.
                        r_full  <= 1'b1;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_next_addr <= r_next_addr + ADDR_ONE;
                     end
                  end
               end
            end

            S_FLUSH: begin
               r_wren    <= 1'b1;
               r_wr_addr <= r_next_addr;
               r_wr_data <= w_run_word;
               r_length  <= r_length + LEN_ONE;
               if (w_last_slot) begin
                  // No room left for the end marker.
                  r_full  <= 1'b1;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_next_addr <= r_next_addr + ADDR_ONE;
                  r_state     <= S_MARK;
               end
            end

            S_MARK: begin
               r_wren    <= 1'b1;
               r_wr_addr <= r_next_addr;
               r_wr_data <= '0;
               r_state   <= S_DONE;
               r_busy    <= 1'b0;
               r_done    <= 1'b1;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wren    = r_wren;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.full    = r_full;
   assign bus.length  = r_length;

endmodule
